logic_unit_pipe: RTL

- Parametrised, pipelined bitwise logic unit; the registered successor to our fixed 4-bit combinational gate blocks.
- Per transaction it applies one of eight gate operations (AND, OR, NOT, BUF, XOR, NAND, NOR, XNOR) to two WIDTH-bit operands, with an accumulate mode that substitutes the previous result for B.
- Uses valid/ready handshakes on both sides, 2-cycle latency and full throughput with backpressure.
- Sits between operand sources and downstream datapath logic.

---
 rtl/logic_unit_pkg.sv | 21 ++
 rtl/logic_unit_core.sv | 32 +++
 rtl/logic_unit_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
//   OP_W        : width of the in_op field (bits [2:0] gate select, bit 3 accumulate)
//   OP_ACC_BIT  : position of the accumulate-mode flag inside in_op
//   op_e        : the eight gate operations
package logic_unit_pkg;

  localparam int unsigned OP_W       = 4;
  localparam int unsigned OP_ACC_BIT = 3;

  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpNotA = 3'd2,
    OpBufA = 3'd3,
    OpXor  = 3'd4,
    OpNand = 3'd5,
    OpNor  = 3'd6,
    OpXnor = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit gate function.
// Ports:
//   op : gate select (op_e)
//   a  : operand A
//   b  : operand B (unused by NOT A / BUF A)
//   y  : result
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OpAnd:  y = a & b;
      OpOr:   y = a | b;
      OpNotA: y = ~a;
      OpBufA: y = a;
      OpXor:  y = a ^ b;
      OpNand: y = ~(a & b);
      OpNor:  y = ~(a | b);
      OpXnor: y = ~(a ^ b);
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// Stage 1 registers the operands; the gate function sits between stage 1 and
// the output register. In accumulate mode (in_op[3]) operand B is replaced by
// the accumulator, which captures every computed result.
// Optional feature macro: LOGIC_UNIT_PARITY_EN adds out_par (even parity of out_data).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational from out_ready)
//   in_op, A, B         : operation and operands
//   acc_clr             : synchronous accumulator clear
//   out_valid/out_ready : result handshake
//   out_data            : result
//   out_par             : parity of out_data (LOGIC_UNIT_PARITY_EN only)
//   out_cnt             : wrapping count of results accepted downstream
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] out_cnt
);

  logic             s1_valid_q;
  logic [OP_W-1:0]  s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_en, s1_en, xfer;
  logic [WIDTH-1:0] b_eff, y;

  assign s2_en = !s2_valid_q || out_ready;
  assign s1_en = !s1_valid_q || s2_en;
  assign xfer  = s1_valid_q && s2_en;

  // Registers are already clear under reset; the explicit term keeps in_ready
  // high for the whole reset window regardless of out_ready.
  assign in_ready = s1_en || !rst_n;

  // Accumulate mode reads acc at transfer time, so a chained op sees the
  // result written at the previous edge.
  assign b_eff = s1_op_q[OP_ACC_BIT] ? acc_q : s1_b_q;

  logic_unit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op(op_e'(s1_op_q[2:0])),
    .a (s1_a_q),
    .b (b_eff),
    .y (y)
  );

  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;  // clear wins over a same-cycle load
    end else if (xfer) begin
      acc_d = y;
    end
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q <= in_op;
          s1_a_q  <= A;
          s1_b_q  <= B;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
      end
      if (xfer) begin
        s2_data_q <= y;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (xfer) begin
      par_q <= ^y;
    end
  end

  assign out_par = par_q;
`endif

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_cnt   = cnt_q;

endmodule
